// File: rtl/div_sched_pkg.sv
// Shared types and constants for the round-robin divider scheduler.
// Optional build macro: DIV_FASTPATH_EN (1-cycle A<B and B==1 results).
package div_sched_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int REM_W      = 16;
    localparam int CNT_W      = 4;

    localparam logic [DIVIDEND_W-1:0] DBZ_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_iter_core.sv
// Iterative 16/8 restoring divider, one quotient bit per cycle, MSB first.
// done_o/quot_o/rem_o present the final step's result combinationally.
module div_iter_core
    import div_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] a_i,
    input  logic [DIVISOR_W-1:0]  b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DIVIDEND_W-1:0] quot_o,
    output logic [DIVISOR_W-1:0]  rem_o
);

    logic [DIVIDEND_W-1:0] a_q;
    logic [DIVISOR_W-1:0]  b_q;
    logic [DIVIDEND_W-1:0] quot_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  busy_q;

    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W-1:0]  diff;
    logic                  ge;
    logic [DIVIDEND_W-1:0] quot_d;
    logic [DIVISOR_W-1:0]  rem_d;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial  = {rem_q, a_q[cnt_q]};
        ge     = (trial >= {1'b0, b_q});
        diff   = trial[DIVISOR_W-1:0] - b_q;
        quot_d = quot_q;
        if (ge) begin
            quot_d[cnt_q] = 1'b1;
        end
        rem_d = ge ? diff : trial[DIVISOR_W-1:0];
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == '0);
    assign quot_o = quot_d;
    assign rem_o  = rem_d;

    // Operand load on start, then 16 iterations counting down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            quot_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '1;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/div_rr_sched.sv
// Round-robin scheduler sharing one iterative divider among NUM_REQ clients.
// Optional build macro: DIV_FASTPATH_EN (1-cycle A<B and B==1 results).
module div_rr_sched
    import div_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [DIVIDEND_W*NUM_REQ-1:0]   req_a,
    input  logic [DIVISOR_W*NUM_REQ-1:0]    req_b,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [ID_W-1:0]                 resp_id,
    output logic [DIVIDEND_W-1:0]           resp_quot,
    output logic [REM_W-1:0]                resp_rem,
    output logic                            resp_dbz
);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic                  dbz_q, dbz_d;

    logic                  gnt_vld;
    logic [ID_W-1:0]       gnt_id;
    logic [ID_W:0]         idx;
    logic [DIVIDEND_W-1:0] sel_a;
    logic [DIVISOR_W-1:0]  sel_b;

    logic                  core_start;
    logic                  core_busy;
    logic                  core_done;
    logic [DIVIDEND_W-1:0] core_quot;
    logic [DIVISOR_W-1:0]  core_rem;

    // First valid requester at or after rr_ptr, searching upward with wrap.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_vld && req_valid[idx[ID_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx[ID_W-1:0];
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                sel_a = req_a[DIVIDEND_W*i +: DIVIDEND_W];
                sel_b = req_b[DIVISOR_W*i +: DIVISOR_W];
            end
        end
    end

    // Accept is offered only in IDLE, and only to the granted requester.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_vld) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // Scheduler FSM and response register next-state.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        core_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    id_d     = gnt_id;
                    rr_ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ?
                               '0 : gnt_id + 1'b1;
                    dbz_d    = 1'b0;
                    state_d  = DONE;
                    if (sel_b == '0) begin
                        quot_d = DBZ_QUOT;
                        rem_d  = sel_a;
                        dbz_d  = 1'b1;
                    end
`ifdef DIV_FASTPATH_EN
                    else if (sel_a < REM_W'(sel_b)) begin
                        quot_d = '0;
                        rem_d  = sel_a;
                    end else if (sel_b == DIVISOR_W'(1)) begin
                        quot_d = sel_a;
                        rem_d  = '0;
                    end
`endif
                    else begin
                        state_d    = CALC;
                        core_start = 1'b1;
                    end
                end
            end
            CALC: begin
                if (!core_busy) begin
                    state_d = IDLE;
                end else if (core_done) begin
                    state_d = DONE;
                    quot_d  = core_quot;
                    rem_d   = REM_W'(core_rem);
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, round-robin pointer and held response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
        end
    end

    assign resp_valid = (state_q == DONE);
    assign resp_id    = id_q;
    assign resp_quot  = quot_q;
    assign resp_rem   = rem_q;
    assign resp_dbz   = dbz_q;

    div_iter_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (core_start),
        .a_i     (sel_a),
        .b_i     (sel_b),
        .busy_o  (core_busy),
        .done_o  (core_done),
        .quot_o  (core_quot),
        .rem_o   (core_rem)
    );

endmodule
